// File: rtl/module_pc_sequencer.sv
// Fetch/branch sequencer for module_PC. It holds the PC cleared through a
// power-up interval, then runs a two-cycle FETCH/EXEC loop. Each instruction
// is decoded into a registered pc_op/pc_o command, and the block keeps a
// small return-address stack for CALL/RET.
`timescale 1ns/1ps
module module_pc_sequencer #(
    parameter int ANCHO    = 4,
    parameter int PROF     = 4,
    parameter int ARRANQUE = 645
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 run_i,
    input  logic [3+ANCHO-1:0]   instr_i,
    input  logic                 cond_i,
    input  logic [ANCHO-1:0]     pc_i,
    input  logic [ANCHO-1:0]     pcinc_i,
    output logic [1:0]           pc_op_o,
    output logic [ANCHO-1:0]     pc_o,
    output logic                 halt_o,
    output logic                 err_o
);

    localparam int INSTR_W = 3 + ANCHO;
    localparam int CW      = $clog2(ARRANQUE + 1);
    localparam int SPW     = $clog2(PROF + 1);
    localparam int IW      = (PROF > 1) ? $clog2(PROF) : 1;

    localparam logic [CW-1:0]  CNT_LAST = CW'(ARRANQUE - 1);
    localparam logic [SPW-1:0] SP_FULL  = SPW'(PROF);
    localparam logic [SPW-1:0] SP_ONE   = SPW'(1);

    localparam logic [2:0] S_ARRANQUE = 3'd0;
    localparam logic [2:0] S_IDLE     = 3'd1;
    localparam logic [2:0] S_FETCH    = 3'd2;
    localparam logic [2:0] S_EXEC     = 3'd3;
    localparam logic [2:0] S_HALT     = 3'd4;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_JMP  = 3'b001;
    localparam logic [2:0] OP_JZ   = 3'b010;
    localparam logic [2:0] OP_CALL = 3'b011;
    localparam logic [2:0] OP_RET  = 3'b100;
    localparam logic [2:0] OP_HALT = 3'b101;

    localparam logic [1:0] PC_CLR  = 2'b00;
    localparam logic [1:0] PC_HOLD = 2'b01;
    localparam logic [1:0] PC_INC  = 2'b10;
    localparam logic [1:0] PC_LOAD = 2'b11;

    logic [2:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [SPW-1:0]   sp_q, sp_d;
    logic [1:0]       pc_op_q, pc_op_d;
    logic [ANCHO-1:0] pc_o_q, pc_o_d;
    logic             halt_q, halt_d;
    logic             err_q, err_d;
    logic             push;

    // Stack storage is rounded up to a power of two so indices never run out of range.
    logic [ANCHO-1:0] stk_q [2**IW];

    logic [2:0]       opcode;
    logic [ANCHO-1:0] target;
    logic [IW-1:0]    wr_idx, rd_idx;

    assign opcode = instr_i[INSTR_W-1:ANCHO];
    assign target = instr_i[ANCHO-1:0];
    assign wr_idx = IW'(sp_q);
    assign rd_idx = IW'(sp_q - SP_ONE);

    // Next-state, command decode and stack-pointer update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sp_d    = sp_q;
        pc_op_d = pc_op_q;
        pc_o_d  = pc_o_q;
        halt_d  = halt_q;
        err_d   = err_q;
        push    = 1'b0;
        case (state_q)
            S_ARRANQUE: begin
                pc_op_d = PC_CLR;
                if (cnt_q == CNT_LAST) begin
                    state_d = S_IDLE;
                    pc_op_d = PC_HOLD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_IDLE: begin
                pc_op_d = PC_HOLD;
                if (run_i) state_d = S_FETCH;
            end
            S_FETCH: begin
                pc_op_d = PC_HOLD;
                if (!run_i) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_EXEC;
                    // Non-load commands leave pc_o pointing at the instruction just decoded.
                    pc_o_d  = pc_i;
                    pc_op_d = PC_INC;
                    case (opcode)
                        OP_JMP: begin
                            pc_op_d = PC_LOAD;
                            pc_o_d  = target;
                        end
                        OP_JZ: begin
                            if (!cond_i) begin
                                pc_op_d = PC_LOAD;
                                pc_o_d  = target;
                            end
                        end
                        OP_CALL: begin
                            if (sp_q == SP_FULL) begin
                                pc_op_d = PC_HOLD;
                                err_d   = 1'b1;
                                halt_d  = 1'b1;
                                state_d = S_HALT;
                            end else begin
                                push    = 1'b1;
                                sp_d    = sp_q + SP_ONE;
                                pc_op_d = PC_LOAD;
                                pc_o_d  = target;
                            end
                        end
                        OP_RET: begin
                            if (sp_q == '0) begin
                                pc_op_d = PC_HOLD;
                                err_d   = 1'b1;
                                halt_d  = 1'b1;
                                state_d = S_HALT;
                            end else begin
                                sp_d    = sp_q - SP_ONE;
                                pc_op_d = PC_LOAD;
                                pc_o_d  = stk_q[rd_idx];
                            end
                        end
                        OP_HALT: begin
                            pc_op_d = PC_HOLD;
                            halt_d  = 1'b1;
                            state_d = S_HALT;
                        end
                        default: pc_op_d = PC_INC;
                    endcase
                end
            end
            S_EXEC: begin
                pc_op_d = PC_HOLD;
                state_d = S_FETCH;
            end
            S_HALT: begin
                pc_op_d = PC_HOLD;
                halt_d  = 1'b1;
            end
            default: begin
                state_d = S_ARRANQUE;
                cnt_d   = '0;
                pc_op_d = PC_CLR;
            end
        endcase
    end

    // Control and output registers; reset restarts the power-up interval and empties the stack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_ARRANQUE;
            cnt_q   <= '0;
            sp_q    <= '0;
            pc_op_q <= PC_CLR;
            pc_o_q  <= '0;
            halt_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sp_q    <= sp_d;
            pc_op_q <= pc_op_d;
            pc_o_q  <= pc_o_d;
            halt_q  <= halt_d;
            err_q   <= err_d;
        end
    end

    // Return-address storage; contents are meaningless above sp so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) stk_q[wr_idx] <= pcinc_i;
    end

    assign pc_op_o = pc_op_q;
    assign pc_o    = pc_o_q;
    assign halt_o  = halt_q;
    assign err_o   = err_q;

endmodule

// File: doc/module_pc_sequencer.md
Name: module_pc_sequencer

Overview:
- Fetch/branch controller that drives module_PC: it issues pc_op and the jump target, and consumes the PC value and PC+1 that module_PC returns.
- Reads the instruction word that ROM returns for the current PC, decodes it, and sequences NOP/JMP/JZ/CALL/RET/HALT.
- Keeps a small return-address stack.
- Includes the power-up hold interval that the PC otherwise gets from the bench.

Parameters:
ANCHO, 4, PC/address width; the instruction word is 3+ANCHO bits (localparam INSTR_W).
PROF, 4, return-stack depth in entries (>=1).
ARRANQUE, 645, power-up hold length in clk cycles (6450 ns at 10 ns clk); must be >=1.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
run_i  in  1  run enable; low pauses sequencing at the next FETCH
instr_i  in  INSTR_W  ROM word at address pc_i; [INSTR_W-1:ANCHO] = opcode, [ANCHO-1:0] = target
cond_i  in  1  branch condition for JZ; taken when 0
pc_i  in  ANCHO  current PC (module_PC pc_o)
pcinc_i  in  ANCHO  PC+1 (module_PC pcinc_o)
pc_op_o  out  2  PC command: 00 clear, 01 hold, 10 increment, 11 load pc_o
pc_o  out  ANCHO  load target for module_PC pc_i
halt_o  out  1  high in HALT state
err_o  out  1  sticky stack overflow/underflow flag

Behaviour:
- All outputs are registered. Reset (async, rst_n=0): pc_op_o=00, pc_o=0, halt_o=0, err_o=0, sp=0 (stack empty), state=ARRANQUE, hold counter=0. Stack contents are don't-care.
- ARRANQUE state: pc_op_o=00 for ARRANQUE cycles; the counter is $clog2(ARRANQUE+1) bits. After the last count, go to IDLE.
- IDLE: pc_op_o=01. Go to FETCH on the first edge with run_i=1.
- FETCH: pc_op_o=01. instr_i must be stable by the end of this cycle (1-cycle ROM). On the edge:
  - if run_i=0, go to IDLE;
  - otherwise decode, load pc_op_o/pc_o, and go to EXEC.
- EXEC: holds the decoded command for exactly one cycle; module_PC applies it on the edge leaving EXEC. Next state is FETCH with pc_op_o=01. One instruction therefore takes 2 cycles.
- Decode (opcode):
  - 000 NOP: op 10.
  - 001 JMP: op 11, pc_o=target.
  - 010 JZ: if cond_i=0, op 11 with pc_o=target; else op 10. cond_i is sampled on the FETCH edge.
  - 011 CALL: push pcinc_i, op 11, pc_o=target.
  - 100 RET: pop, op 11, pc_o=popped value.
  - 101 HALT: op 01, go to HALT.
  - 110/111: treated as NOP.
- Stack:
  - CALL with sp=PROF (full): no push; set err_o, op 01, go to HALT.
  - RET with sp=0 (empty): no pop; set err_o, op 01, go to HALT.
  - sp changes only on the FETCH->EXEC edge.
- HALT: pc_op_o=01, halt_o=1. Only rst_n exits; run_i is ignored.
- err_o: stays 1 until reset.
- Wrap-around: PC increment wraps modulo 2^ANCHO inside module_PC. CALL at address 2^ANCHO-1 pushes pcinc_i=0, and RET returns to 0.
- run_i deasserted in EXEC: the EXEC command still completes; pause occurs at the following FETCH.
- Reset mid-operation: outputs revert immediately (async) to reset values, the stack empties, and the ARRANQUE interval restarts.

Test Plan:
All scenarios use ANCHO=4, PROF=2, ARRANQUE=3, 10 ns clk.

1. Release rst_n, run_i=1: pc_op_o=00 for exactly 3 cycles, then 01 (IDLE, FETCH), then first EXEC. halt_o=0, err_o=0 throughout.
2. ROM of NOPs: pc_op_o alternates 01/10. PC advances 0,1,...,15,0 (wrap), one step per 2 cycles.
3. JMP 0011 at addr 2: EXEC shows pc_op_o=11, pc_o=0011, and the next pc_i=3. JZ with cond_i=1 gives op 10; with cond_i=0 it gives op 11 to the target.
4. CALL 1000 at addr 5, then RET at 8: push 6 and load 8; RET loads 6. Two nested CALLs succeed; a third sets err_o=1, halt_o=1, pc_op_o=01.
5. RET with empty stack: err_o=1, halt_o=1, and PC frozen. run_i toggling has no effect; only rst_n clears both flags.
6. Deassert run_i during FETCH: pc_op_o stays 01 and PC holds. Reasserting run_i resumes at the same PC. Pulsing rst_n low mid-EXEC immediately forces pc_op_o=00, pc_o=0, sp=0.
